// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg
// Shared opcodes, reply bytes, decoder state type and a saturating
// increment helper for the SPI command handler.
package spi_cmd_pkg;

    localparam logic [7:0] OP_DATA0      = 8'h00;
    localparam logic [7:0] OP_DATA1      = 8'h01;
    localparam logic [7:0] OP_GET_STATE  = 8'hFF;
    localparam logic [7:0] OP_GET_STATUS = 8'hE0;
    localparam logic [7:0] OP_CLEAR_ERR  = 8'hE1;
    localparam logic [7:0] OP_BURST      = 8'hC0;

    localparam logic [7:0] ACK_BYTE = 8'h5A;
    localparam logic [7:0] NAK_BYTE = 8'hEE;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BURST_LEN  = 2'd1,
        BURST_DATA = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/spi_cmd_handler_timeout.sv
// spi_cmd_timeout
// Inter-byte watchdog for bursts. A down-counter reloads to
// TIMEOUT_CYCLES-1 on clear and decrements while enabled; expire pulses
// in the enabled, uncleared cycle in which the count has reached zero.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   clear   reload the counter (byte received or not in a burst)
//   enable  count this cycle
//   expire  single-cycle timeout indication
module spi_cmd_timeout
    import spi_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] RELOAD = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RELOAD;
        end else if (clear) begin
            count <= RELOAD;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // A byte arriving in the expiry cycle wins: clear masks the pulse.
    assign expire = enable && !clear && (count == '0);

endmodule

// File: rtl/spi_cmd_handler.sv
// spi_cmd_handler
// Decodes bytes received from the SPI slave, forwards data bits to the
// lab FSM as one-cycle enables and loads a reply byte into the slave TX
// buffer for every received byte. All outputs are registered with a
// fixed latency of one cycle from i_RX_DV.
// Ports:
//   i_Clk      system clock (CLOCK_50)
//   i_Rst      synchronous active-high reset
//   i_RX_DV    received byte valid pulse
//   i_RX_Byte  received byte
//   i_State    FSM state, sampled on GET_STATE
//   o_Data_en  data enable pulse to the FSM
//   o_Data     data bit to the FSM, held between pulses
//   o_TX_DV    reply load pulse to the SPI slave
//   o_TX_Byte  reply byte, held between pulses
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | decode each byte as an opcode
// BURST_LEN  | next byte is the burst length
// BURST_DATA | every byte is data until remaining reaches 0
module spi_cmd_handler
    import spi_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    input  logic [7:0] i_State,
    output logic       o_Data_en,
    output logic       o_Data,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte
);

    state_t     state, state_next;
    logic [7:0] remaining, remaining_next;
    logic [7:0] err_cnt, err_cnt_next;
    logic       data_en_next, data_next, tx_dv_next;
    logic [7:0] tx_byte_next;
    logic       expire;

    // Outside a burst the timer is held at its reload value, so entering
    // BURST_LEN always starts from a fresh count.
    spi_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (i_Clk),
        .rst    (i_Rst),
        .clear  (i_RX_DV || (state == IDLE)),
        .enable (state != IDLE),
        .expire (expire)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= IDLE;
            remaining <= 8'h00;
            err_cnt   <= 8'h00;
            o_Data_en <= 1'b0;
            o_Data    <= 1'b0;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= 8'h00;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            err_cnt   <= err_cnt_next;
            o_Data_en <= data_en_next;
            o_Data    <= data_next;
            o_TX_DV   <= tx_dv_next;
            o_TX_Byte <= tx_byte_next;
        end
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        err_cnt_next   = err_cnt;
        data_en_next   = 1'b0;
        data_next      = o_Data;
        tx_dv_next     = 1'b0;
        tx_byte_next   = o_TX_Byte;

        if (i_RX_DV) begin
            tx_dv_next = 1'b1;
            case (state)
                IDLE: begin
                    case (i_RX_Byte)
                        OP_DATA0, OP_DATA1: begin
                            data_en_next = 1'b1;
                            data_next    = i_RX_Byte[0];
                            tx_byte_next = ACK_BYTE;
                        end
                        OP_GET_STATE:  tx_byte_next = i_State;
                        OP_GET_STATUS: tx_byte_next = err_cnt;
                        OP_CLEAR_ERR: begin
                            err_cnt_next = 8'h00;
                            tx_byte_next = ACK_BYTE;
                        end
                        OP_BURST: begin
                            tx_byte_next = ACK_BYTE;
                            state_next   = BURST_LEN;
                        end
                        default: begin
                            err_cnt_next = sat_inc(err_cnt);
                            tx_byte_next = NAK_BYTE;
                        end
                    endcase
                end
                BURST_LEN: begin
                    if (i_RX_Byte == 8'h00) begin
                        tx_byte_next = ACK_BYTE;
                        state_next   = IDLE;
                    end else begin
                        remaining_next = i_RX_Byte;
                        tx_byte_next   = i_RX_Byte;
                        state_next     = BURST_DATA;
                    end
                end
                BURST_DATA: begin
                    data_en_next   = 1'b1;
                    data_next      = i_RX_Byte[0];
                    remaining_next = remaining - 8'd1;
                    tx_byte_next   = remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (expire) begin
            state_next     = IDLE;
            remaining_next = 8'h00;
            err_cnt_next   = sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_spi_cmd_handler.sv
module tb_spi_cmd_handler;

    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic [7:0] state_in;
    logic       data_en, data_bit, tx_dv;
    logic [7:0] tx_byte;

    int errors = 0;
    int checks = 0;

    spi_cmd_handler #(.TIMEOUT_CYCLES(T)) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_RX_DV   (rx_dv),
        .i_RX_Byte (rx_byte),
        .i_State   (state_in),
        .o_Data_en (data_en),
        .o_Data    (data_bit),
        .o_TX_DV   (tx_dv),
        .o_TX_Byte (tx_byte)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks what the protocol means (waiting for a
    // length, bytes left in the burst, error tally, idle cycles) and
    // produces the reply expected one cycle after each received byte.
    bit         model_ready = 0;
    bit         want_len = 0;
    int         left = 0;
    int         errs = 0;
    int         idle_cnt = 0;
    logic       exp_den, exp_d, exp_txdv;
    logic [7:0] exp_tx;

    always @(posedge clk) begin
        if (rst) begin
            model_ready = 1;
            want_len = 0; left = 0; errs = 0; idle_cnt = 0;
            exp_den = 0; exp_d = 0; exp_txdv = 0; exp_tx = 8'h00;
        end else begin
            exp_den = 0;
            exp_txdv = 0;
            if (rx_dv) begin
                exp_txdv = 1;
                idle_cnt = 0;
                if (want_len) begin
                    want_len = 0;
                    if (rx_byte == 0) exp_tx = 8'h5A;
                    else begin left = rx_byte; exp_tx = rx_byte; end
                end else if (left > 0) begin
                    exp_den = 1;
                    exp_d = rx_byte[0];
                    left = left - 1;
                    exp_tx = 8'(left);
                end else if (rx_byte == 8'h00 || rx_byte == 8'h01) begin
                    exp_den = 1; exp_d = rx_byte[0]; exp_tx = 8'h5A;
                end else if (rx_byte == 8'hFF) exp_tx = state_in;
                else if (rx_byte == 8'hE0) exp_tx = 8'(errs);
                else if (rx_byte == 8'hE1) begin errs = 0; exp_tx = 8'h5A; end
                else if (rx_byte == 8'hC0) begin want_len = 1; exp_tx = 8'h5A; end
                else begin
                    errs = (errs < 255) ? errs + 1 : 255;
                    exp_tx = 8'hEE;
                end
            end else if (want_len || left > 0) begin
                if (idle_cnt == T - 1) begin
                    want_len = 0; left = 0; idle_cnt = 0;
                    errs = (errs < 255) ? errs + 1 : 255;
                end else idle_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            check("model_data_en", {7'b0, data_en}, {7'b0, exp_den});
            check("model_data", {7'b0, data_bit}, {7'b0, exp_d});
            check("model_tx_dv", {7'b0, tx_dv}, {7'b0, exp_txdv});
            check("model_tx_byte", tx_byte, exp_tx);
        end
    end

    // Each task leaves time at 1 ns after a rising edge; send() leaves the
    // outputs showing the reply to the byte it sent.
    task automatic send(input logic [7:0] b);
        rx_dv = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; state_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_tx_byte", tx_byte, 8'h00);
        check("reset_tx_dv", {7'b0, tx_dv}, 8'h00);
        check("reset_data_en", {7'b0, data_en}, 8'h00);
        idle(2);

        send(8'h01);
        check("data1_en", {7'b0, data_en}, 8'h01);
        check("data1_bit", {7'b0, data_bit}, 8'h01);
        check("data1_txdv", {7'b0, tx_dv}, 8'h01);
        check("data1_ack", tx_byte, 8'h5A);
        idle(1);
        check("data1_en_low", {7'b0, data_en}, 8'h00);
        check("data1_txdv_low", {7'b0, tx_dv}, 8'h00);
        check("data1_hold", tx_byte, 8'h5A);

        state_in = 8'h03;
        send(8'hFF);
        state_in = 8'h02;
        check("get_state", tx_byte, 8'h03);
        idle(1);
        check("get_state_hold", tx_byte, 8'h03);

        send(8'hC0); check("burst_ack", tx_byte, 8'h5A);
        send(8'h03); check("burst_len", tx_byte, 8'h03);
        send(8'hFF); check("burst_r2", tx_byte, 8'h02);
        check("burst_d0", {7'b0, data_bit}, 8'h01);
        send(8'h00); check("burst_r1", tx_byte, 8'h01);
        check("burst_d1", {7'b0, data_bit}, 8'h00);
        send(8'h01); check("burst_r0", tx_byte, 8'h00);
        check("burst_d2", {7'b0, data_bit}, 8'h01);
        send(8'hFF); check("post_burst_state", tx_byte, 8'h02);
        idle(1);

        send(8'hC0);
        send(8'h00); check("burst_zero_len", tx_byte, 8'h5A);
        send(8'hFF); check("zero_len_idle", tx_byte, 8'h02);
        idle(2);

        // Byte arriving in the expiry cycle is still data.
        send(8'hC0);
        send(8'h05);
        send(8'h01); check("to_r4", tx_byte, 8'h04);
        idle(T - 1);
        send(8'h01); check("to_boundary_byte", tx_byte, 8'h03);
        idle(T);
        check("to_no_pulse", {7'b0, tx_dv}, 8'h00);
        send(8'hE0); check("to_err_count", tx_byte, 8'h01);
        idle(1);

        for (int i = 0; i < 300; i++) begin
            send(8'h7B);
            check("nak", tx_byte, 8'hEE);
        end
        send(8'hE0); check("err_saturated", tx_byte, 8'hFF);
        send(8'hE1); check("clear_ack", tx_byte, 8'h5A);
        send(8'hE0); check("err_cleared", tx_byte, 8'h00);
        idle(1);

        send(8'hC0);
        send(8'h04);
        send(8'h01);
        send(8'h00); check("pre_reset_r2", tx_byte, 8'h02);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_tx_byte", tx_byte, 8'h00);
        check("rst_mid_txdv", {7'b0, tx_dv}, 8'h00);
        check("rst_mid_data", {7'b0, data_bit}, 8'h00);
        idle(1);
        check("after_rst_txdv", {7'b0, tx_dv}, 8'h00);
        send(8'h00);
        check("after_rst_den", {7'b0, data_en}, 8'h01);
        check("after_rst_data", {7'b0, data_bit}, 8'h00);
        check("after_rst_ack", tx_byte, 8'h5A);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_handler.md
# spi_cmd_handler

Command decoder between the SPI slave byte interface and the lab FSM. It consumes each received byte (RX_DV/RX_Byte) and forwards data bits to the FSM as single-cycle enables. It answers every byte by loading a reply (ACK, FSM state, status, or burst countdown) into the slave's TX buffer for the next SPI transaction. It runs entirely in the CLOCK_50 domain.

## Interface
- TIMEOUT_CYCLES, 50000: idle cycles allowed between bytes inside a burst before abort (1 ms at 50 MHz); must be ≥2.
- i_Clk  in  1  system clock (CLOCK_50).
- i_Rst  in  1  reset. One clock; reset is synchronous and active-high.
- i_RX_DV  in  1  one-cycle pulse: i_RX_Byte valid.
- i_RX_Byte  in  8  received byte from SPI slave.
- i_State  in  8  current FSM state, sampled on GET_STATE.
- o_Data_en  out  1  one-cycle pulse to FSM data enable.
- o_Data  out  1  data bit to FSM, valid while o_Data_en=1, held otherwise.
- o_TX_DV  out  1  one-cycle pulse: load o_TX_Byte into SPI slave.
- o_TX_Byte  out  8  reply byte, held between pulses.

## Operation
- Opcodes in IDLE:
  - 0x00/0x01 DATA: o_Data_en pulse, o_Data=byte[0]; reply ACK 0x5A.
  - 0xFF GET_STATE: reply = i_State sampled in the RX_DV cycle.
  - 0xE0 GET_STATUS: reply = err_cnt.
  - 0xE1 CLEAR_ERR: err_cnt←0; reply 0x5A.
  - 0xC0 BURST: reply 0x5A; go to BURST_LEN.
  - Any other byte: err_cnt+1 (saturates at 0xFF); reply NAK 0xEE.
- BURST_LEN: byte N is the burst length.
  - N=0: reply 0x5A; return to IDLE.
  - N>0: remaining←N; reply N; go to BURST_DATA.
- BURST_DATA: every byte is data, no opcode decoding (0xFF is data here).
  - o_Data_en pulse, o_Data=byte[0].
  - remaining←remaining−1; reply the new remaining value.
  - Reaching 0 returns to IDLE.
- Timeout: in BURST_LEN/BURST_DATA, a counter increments each cycle without i_RX_DV and clears on i_RX_DV or state entry.
  - Reaching TIMEOUT_CYCLES−1 with no RX_DV: go to IDLE; err_cnt+1 (saturating); no TX pulse, no data pulse.
- err_cnt is 8-bit, saturating; it only changes on NAK, timeout, or CLEAR_ERR.

## Timing
- All outputs registered.
- i_RX_DV high in cycle t → o_TX_DV, o_TX_Byte, o_Data_en, o_Data updated in t+1. Fixed latency 1.
- Exactly one o_TX_DV pulse per accepted byte; o_Data_en pulses only for DATA opcodes and BURST_DATA bytes.
- i_RX_DV is processed whenever present: no back-pressure, and back-to-back pulses in consecutive cycles are each handled.
- Simultaneous RX_DV and timeout expiry: the byte wins, the timer clears, and no error is counted.
- Reset values: state=IDLE, remaining=0, err_cnt=0, timer=0, o_Data_en=0, o_Data=0, o_TX_DV=0, o_TX_Byte=0x00.
- Reset asserted mid-burst: IDLE on the next edge; no pulses in the cycle after reset; the first post-reset byte is decoded as an opcode.
- Pulse outputs deassert the cycle after assertion; byte outputs hold their value.

## Structure
- Package spi_cmd_pkg:
  - Opcode constants: OP_DATA0/1, OP_GET_STATE, OP_GET_STATUS, OP_CLEAR_ERR, OP_BURST.
  - Reply constants: ACK_BYTE=0x5A, NAK_BYTE=0xEE.
  - State enum: IDLE, BURST_LEN, BURST_DATA.
- Sub-module spi_cmd_timeout:
  - Parameterised down-counter with clear/enable, width $clog2(TIMEOUT_CYCLES).
  - Outputs an expire pulse.
- Top level sits between SPI_Slave and fsm in the lab top, replacing the direct wiring.

## Test plan
- Reset, then RX 0x01 → one cycle later o_Data_en=1, o_Data=1, o_TX_DV=1, o_TX_Byte=0x5A; all pulses low the following cycle.
- i_State=0x03, RX 0xFF → o_TX_Byte=0x03. Change i_State to 0x02 after the RX cycle → reply stays 0x03.
- RX 0xC0, 0x03, 0xFF, 0x00, 0x01 → replies 0x5A, 0x03, 0x02, 0x01, 0x00; o_Data sequence 1, 0, 1; back in IDLE. A following 0xFF returns state.
- TIMEOUT_CYCLES=20: RX 0xC0, 0x05, one data byte, then silence → IDLE after 20 cycles, no output pulses. RX 0xE0 → reply 0x01.
- Send 300 bytes of 0x7B → 300 NAKs 0xEE. RX 0xE0 → 0xFF (saturated). RX 0xE1, then 0xE0 → 0x5A, then 0x00.
- Reset asserted while remaining=2 in BURST_DATA → outputs at reset values. Next RX 0x00 → treated as DATA: o_Data=0, reply 0x5A.
